// File: rtl/ans_l_stf_seq.sv
// L-STF sequencer: steps the combinational generator through NUM_REP periods
// of 16 samples and streams the results through a registered valid/ready stage.
module ans_l_stf_seq #(
    parameter int NUM_REP   = 10,
    parameter bit WINDOW_EN = 1'b1
) (
    input  logic        clk,
    input  logic        phy_tx_arest,
    input  logic        start,
    input  logic [23:0] coeffs_in,
    output logic        busy,
    output logic [3:0]  stf_addr,
    output logic [23:0] stf_coeffs,
    input  logic [31:0] stf_symbol,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_addr;
    logic [3:0]         r_rep;
    logic [23:0]        r_coeffs;
    logic [31:0]        r_data;
    logic               r_valid;
    logic               r_last;

    logic               w_load;
    logic               w_accept;
    logic               w_final;
    logic               w_first;
    logic signed [15:0] w_i;
    logic signed [15:0] w_q;
    logic signed [15:0] w_i_win;
    logic signed [15:0] w_q_win;

    // Output register refills when empty or when its current beat leaves this cycle.
    assign w_load   = (r_state == S_RUN) && (!r_valid || out_ready);
    assign w_accept = r_valid && out_ready;
    assign w_final  = (r_rep == 4'(NUM_REP - 1)) && (r_addr == 4'hF);
    assign w_first  = (r_rep == 4'd0) && (r_addr == 4'd0);

    // Edge window: only the very first sample of the burst is halved (floor shift).
    assign w_i     = $signed(stf_symbol[31:16]);
    assign w_q     = $signed(stf_symbol[15:0]);
    assign w_i_win = (WINDOW_EN && w_first) ? (w_i >>> 1) : w_i;
    assign w_q_win = (WINDOW_EN && w_first) ? (w_q >>> 1) : w_q;

    // State register.
    always_ff @(posedge clk) begin
        if (phy_tx_arest) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: RUN until the final sample is loaded, FLUSH until it is taken.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_load && w_final) w_next = S_FLUSH;
            S_FLUSH: if (w_accept) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: coefficient latch, address/repetition counters and output register.
    always_ff @(posedge clk) begin
        if (phy_tx_arest) begin
            r_addr   <= 4'd0;
            r_rep    <= 4'd0;
            r_coeffs <= 24'd0;
            r_data   <= 32'd0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_coeffs <= coeffs_in;
                r_addr   <= 4'd0;
                r_rep    <= 4'd0;
            end
            if (w_load) begin
                r_data  <= {w_i_win, w_q_win};
                r_valid <= 1'b1;
                r_last  <= w_final;
                r_addr  <= r_addr + 4'd1;
                if (r_addr == 4'hF) begin
                    r_rep <= r_rep + 4'd1;
                end
            end else if (w_accept) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign stf_addr   = r_addr;
    assign stf_coeffs = r_coeffs;
    assign out_data   = r_data;
    assign out_valid  = r_valid;
    assign out_last   = r_last;

endmodule

// File: tb/tb_ans_l_stf_seq.sv
// Bench for ans_l_stf_seq: stimulus pushes expected beats into a queue, an
// independent negedge monitor pops and compares every accepted beat.
module tb_ans_l_stf_seq;

    localparam int NREP   = 10;
    localparam int NBEATS = 16 * NREP;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] coeffs_in;
    logic        busy;
    logic [3:0]  stf_addr;
    logic [23:0] stf_coeffs;
    logic [31:0] stf_symbol;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        done;

    always #5 clk = ~clk;

    ans_l_stf_seq #(.NUM_REP(NREP), .WINDOW_EN(1'b1)) dut (
        .clk(clk), .phy_tx_arest(rst), .start(start), .coeffs_in(coeffs_in),
        .busy(busy), .stf_addr(stf_addr), .stf_coeffs(stf_coeffs),
        .stf_symbol(stf_symbol), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .done(done)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [23:0] exp_coeffs = 24'd0;
    int          ready_mode = 0;
    int          beat_cnt = 0;
    int          busy_cycles = 0;
    int          stall_cycles = 0;
    int          bursts_done = 0;
    bit          exp_done = 1'b0;
    bit          prev_stall = 1'b0;
    bit          prev_rst = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic        prev_last = 1'b0;

    // Generator stand-in; address 0 with 0xA5A5A5 gives the known symbol 0x4000C000.
    function automatic logic [31:0] gen(input logic [3:0] a, input logic [23:0] c);
        if (a == 4'd0 && c == 24'hA5A5A5) return 32'h4000C000;
        return {c[15:0] ^ {a, a, a, a}, c[23:8] + {a, 4'h0, a, 4'h3}};
    endfunction

    always_comb stf_symbol = gen(stf_addr, stf_coeffs);

    function automatic logic [15:0] half_floor(input logic [15:0] v);
        int x;
        int q;
        x = $signed(v);
        q = x / 2;
        if (x < 0 && (x % 2) != 0) q = q - 1;
        return 16'(q);
    endfunction

    // Reference: beat k is generator sample (k mod 16); the first beat is halved.
    function automatic beat_t model(input int k, input logic [23:0] c);
        beat_t b;
        logic [31:0] s;
        s = gen(4'(k % 16), c);
        if (k == 0) s = {half_floor(s[31:16]), half_floor(s[15:0])};
        b.data = s;
        b.last = (k == NBEATS - 1);
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready: always high or a 50% coin flip per cycle.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Monitor: compares accepted beats, hold behaviour, done timing and burst length.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (prev_rst) begin
                    chk("rst_valid", 32'(out_valid), 32'd0);
                    chk("rst_busy", 32'(busy), 32'd0);
                    chk("rst_done", 32'(done), 32'd0);
                    chk("rst_addr", 32'(stf_addr), 32'd0);
                end
                beat_cnt = 0; busy_cycles = 0; stall_cycles = 0;
                exp_done = 1'b0; prev_stall = 1'b0; prev_rst = 1'b1;
            end else begin
                prev_rst = 1'b0;
                chk("done", 32'(done), 32'(exp_done));
                exp_done = 1'b0;
                if (busy) busy_cycles++;
                if (done) begin
                    chk("beats", 32'(beat_cnt), 32'(NBEATS));
                    chk("cycles", 32'(busy_cycles), 32'(NBEATS + stall_cycles + 2));
                    bursts_done++;
                    beat_cnt = 0; busy_cycles = 0; stall_cycles = 0;
                end
                if (prev_stall) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_data", out_data, prev_data);
                    chk("hold_last", 32'(out_last), 32'(prev_last));
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
                if (prev_stall) stall_cycles++;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_beat: got %h expected none at %0t", out_data, $time);
                    end else begin
                        b = exp_q.pop_front();
                        chk("data", out_data, b.data);
                        chk("last", 32'(out_last), 32'(b.last));
                        chk("coeffs", 32'(stf_coeffs), 32'(exp_coeffs));
                        chk("addr", 32'(stf_addr), 32'((beat_cnt + 1) % 16));
                        if (exp_coeffs == 24'hA5A5A5 && beat_cnt == 0) chk("beat0_win", out_data, 32'h2000E000);
                        if (exp_coeffs == 24'hA5A5A5 && beat_cnt == 16) chk("beat16_raw", out_data, 32'h4000C000);
                        if (b.last) exp_done = 1'b1;
                    end
                    beat_cnt++;
                end
            end
        end
    end

    task automatic run_burst(input logic [23:0] c, input int mode, input bit inject, input bit do_rst);
        int t;
        int base;
        ready_mode = mode;
        t = 0;
        while (busy !== 1'b0 || done !== 1'b0) begin
            @(posedge clk); #1; t++;
            if (t > 50) begin
                checks++; errors++;
                $display("FAIL idle_wait: got busy=%b expected 0", busy);
                return;
            end
        end
        base = bursts_done;
        start = 1'b1; coeffs_in = c; exp_coeffs = c;
        for (int k = 0; k < NBEATS; k++) exp_q.push_back(model(k, c));
        @(posedge clk); #1;
        start = 1'b0; coeffs_in = $urandom;
        if (inject) begin
            for (int p = 0; p < 3; p++) begin
                repeat (20 + 30 * p) @(posedge clk);
                #1 start = 1'b1; coeffs_in = 24'hFFFFFF;
                @(posedge clk); #1 start = 1'b0;
            end
        end
        if (do_rst) begin
            t = 0;
            while (beat_cnt < 70) begin
                @(posedge clk); #1; t++;
                if (t > 2000) begin
                    checks++; errors++;
                    $display("FAIL beat70_wait: got %0d beats expected 70", beat_cnt);
                    break;
                end
            end
            rst = 1'b1;
            exp_q.delete();
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            chk("no_done_after_rst", 32'(bursts_done), 32'(base));
            return;
        end
        t = 0;
        while (done !== 1'b1) begin
            @(posedge clk); #1; t++;
            if (t > 2000) begin
                checks++; errors++;
                $display("FAIL done_wait: got done=%b expected 1", done);
                return;
            end
        end
        // A start in the DONE cycle must not launch a burst.
        if (inject) begin
            start = 1'b1; coeffs_in = 24'hFFFFFF;
        end
        @(posedge clk); #1 start = 1'b0;
        chk("burst_count", 32'(bursts_done), 32'(base + 1));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b1; coeffs_in = 24'h123456;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0; start = 1'b0;
        chk("post_rst_coeffs", 32'(stf_coeffs), 32'd0);
        run_burst(24'hA5A5A5, 0, 1'b0, 1'b0);
        run_burst(24'($urandom), 1, 1'b0, 1'b0);
        run_burst(24'($urandom), 1, 1'b1, 1'b0);
        run_burst(24'($urandom), 1, 1'b0, 1'b1);
        run_burst(24'($urandom), 1, 1'b0, 1'b0);
        run_burst(24'($urandom), 0, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        chk("final_idle", 32'(busy), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
